// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and writeback entry type for the register file write path.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t; FIFO_DEPTH must be a power of two.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t push_entry,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int AW = $clog2(FIFO_DEPTH);
  wb_entry_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_entry;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/load results onto the register file write port and tracks busy registers.
// Define REGFILE_WB_FORWARD_EN to add write-cycle forwarding outputs that also mask rsX_busy.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            reserve_valid,
  input  logic [4:0]      reserve_rd,
  output logic            reserve_conflict,
  input  logic [4:0]      rs1_address,
  input  logic [4:0]      rs2_address,
  output logic            rs1_busy,
  output logic            rs2_busy,
`ifdef REGFILE_WB_FORWARD_EN
  output logic            rs1_fwd_hit,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic            rs2_fwd_hit,
  output logic [XLEN-1:0] rs2_fwd_data,
`endif
  output logic            write_enable,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] rd_data
);
  wb_entry_t alu_entry, mem_entry, head, sel;
  logic full, empty, alu_accept, push, pop, sel_valid, do_write;
  logic rs1_pend, rs2_pend;
  logic [NUM_REGS-1:0] busy, set_mask, clr_mask;
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign mem_entry = '{rd: mem_rd, data: mem_data};
  assign alu_ready = !full;
  assign mem_ready = 1'b1;
  assign alu_accept = alu_valid && !full;
  // the ALU result bypasses the FIFO only when nothing older or higher priority is waiting
  assign pop = !mem_valid && !empty;
  assign push = alu_accept && (mem_valid || !empty);
  assign sel = mem_valid ? mem_entry : !empty ? head : alu_entry;
  assign sel_valid = mem_valid || !empty || alu_accept;
  assign do_write = sel_valid && sel.rd != REG_ZERO;
  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_entry(alu_entry),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable <= 1'b0;
      rd_address <= '0;
      rd_data <= '0;
    end else begin
      write_enable <= do_write;
      if (do_write) begin
        rd_address <= sel.rd;
        rd_data <= sel.data;
      end
    end
  end
  always_comb begin
    clr_mask = write_enable ? NUM_REGS'(1) << rd_address : '0;
    set_mask = (reserve_valid && reserve_rd != REG_ZERO) ? NUM_REGS'(1) << reserve_rd : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
      reserve_conflict <= 1'b0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      reserve_conflict <= |(set_mask & busy & ~clr_mask);
    end
  end
  assign rs1_pend = busy[rs1_address] && rs1_address != REG_ZERO;
  assign rs2_pend = busy[rs2_address] && rs2_address != REG_ZERO;
`ifdef REGFILE_WB_FORWARD_EN
  assign rs1_fwd_hit = write_enable && rd_address == rs1_address && rs1_address != REG_ZERO;
  assign rs2_fwd_hit = write_enable && rd_address == rs2_address && rs2_address != REG_ZERO;
  assign rs1_fwd_data = rd_data;
  assign rs2_fwd_data = rd_data;
  assign rs1_busy = rs1_pend && !rs1_fwd_hit;
  assign rs2_busy = rs2_pend && !rs2_fwd_hit;
`else
  assign rs1_busy = rs1_pend;
  assign rs2_busy = rs2_pend;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed stimulus with a write-order scoreboard checked by a negedge monitor.
module tb_regfile_writeback;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  logic clock = 1'b0, reset;
  logic alu_valid, alu_ready, mem_valid, mem_ready, reserve_valid, reserve_conflict;
  logic [4:0] alu_rd, mem_rd, reserve_rd, rs1_address, rs2_address, rd_address;
  logic [31:0] alu_data, mem_data, rd_data;
  logic rs1_busy, rs2_busy, write_enable;
  exp_t exp_q[$];
  exp_t e;
  int vectors = 0, miscompares = 0;
  int k;
  regfile_writeback dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .reserve_valid(reserve_valid), .reserve_rd(reserve_rd), .reserve_conflict(reserve_conflict),
    .rs1_address(rs1_address), .rs2_address(rs2_address), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .write_enable(write_enable), .rd_address(rd_address), .rd_data(rd_data)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain_done", exp_q.size(), 0);
    step();
  endtask
  always @(negedge clock)
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: rd %0d data %0h, no write expected", rd_address, rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", rd_address, e.rd);
        chk("wb_data", rd_data, e.data);
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    {alu_valid, mem_valid, reserve_valid} = '0;
    {alu_rd, mem_rd, reserve_rd, rs1_address, rs2_address} = '0;
    alu_data = '0;
    mem_data = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_we", write_enable, 0);
    chk("rst_rd_address", rd_address, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_conflict", reserve_conflict, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("mem_ready", mem_ready, 1);
    // single ALU result
    exp_q.push_back('{5'd5, 32'hDEADBEEF});
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    chk("t1_we", write_enable, 1);
    step();
    chk("t1_idle_we", write_enable, 0);
    chk("t1_hold_addr", rd_address, 5);
    chk("t1_hold_data", rd_data, 32'hDEADBEEF);
    // load and ALU collide: load first
    exp_q.push_back('{5'd3, 32'h11});
    exp_q.push_back('{5'd4, 32'h22});
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("t2_first_rd", rd_address, 3);
    step();
    chk("t2_second_we", write_enable, 1);
    chk("t2_second_rd", rd_address, 4);
    step();
    chk("t2_idle_we", write_enable, 0);
    // loads hog the port while ALU fills the FIFO
    for (int i = 0; i < 6; i++) exp_q.push_back('{5'(10 + i), 32'(256 + i)});
    for (int i = 1; i <= 6; i++) exp_q.push_back('{5'(i), 32'(160 + i)});
    k = 0;
    for (int c = 0; c < 40; c++) begin
      mem_valid = c < 6; mem_rd = 5'(10 + c); mem_data = 32'(256 + c);
      alu_valid = k < 6; alu_rd = 5'(k + 1); alu_data = 32'(160 + k + 1);
      if (c == 4) begin
        chk("t3_accepts_at_full", k, 4);
        chk("t3_ready_low", alu_ready, 0);
      end
      if (c == 6) chk("t3_ready_low_on_dequeue", alu_ready, 0);
      if (c == 7) chk("t3_ready_back", alu_ready, 1);
      if (alu_valid && alu_ready) k++;
      step();
      if (k == 6 && c >= 6) break;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("t3_all_accepted", k, 6);
    drain();
    // scoreboard and conflict
    reserve_valid = 1'b1; reserve_rd = 5'd7;
    step();
    reserve_valid = 1'b0; rs1_address = 5'd7;
    #1;
    chk("t4_busy_set", rs1_busy, 1);
    reserve_valid = 1'b1;
    step();
    reserve_valid = 1'b0;
    chk("t4_conflict", reserve_conflict, 1);
    step();
    chk("t4_conflict_once", reserve_conflict, 0);
    exp_q.push_back('{5'd7, 32'h77});
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    step();
    alu_valid = 1'b0;
    chk("t4_busy_in_write", rs1_busy, 1);
    step();
    chk("t4_busy_cleared", rs1_busy, 0);
    reserve_valid = 1'b1; reserve_rd = 5'd8;
    step();
    reserve_valid = 1'b0;
    exp_q.push_back('{5'd8, 32'h88});
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    step();
    alu_valid = 1'b0; reserve_valid = 1'b1; reserve_rd = 5'd8;
    step();
    reserve_valid = 1'b0; rs2_address = 5'd8;
    #1;
    chk("t4_set_wins", rs2_busy, 1);
    chk("t4_no_conflict_on_clear", reserve_conflict, 0);
    // x0 results and reservations
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    step();
    alu_valid = 1'b0;
    chk("t5_x0_we", write_enable, 0);
    chk("t5_x0_ready", alu_ready, 1);
    reserve_valid = 1'b1; reserve_rd = 5'd0;
    step();
    step();
    reserve_valid = 1'b0; rs1_address = 5'd0;
    #1;
    chk("t5_x0_busy", rs1_busy, 0);
    chk("t5_x0_conflict", reserve_conflict, 0);
    step();
    chk("t5_still_idle", write_enable, 0);
    // reset drops buffered entries and reservations
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back('{5'(20 + c), 32'(512 + c)});
      mem_valid = 1'b1; mem_rd = 5'(20 + c); mem_data = 32'(512 + c);
      alu_valid = 1'b1; alu_rd = 5'(25 + c); alu_data = 32'(768 + c);
      reserve_valid = c == 0; reserve_rd = 5'd9;
      step();
    end
    mem_valid = 1'b0; alu_valid = 1'b0; reserve_valid = 1'b0; rs1_address = 5'd9;
    #1;
    chk("t6_busy_before_reset", rs1_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_we", write_enable, 0);
    chk("t6_rd_address", rd_address, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_busy_cleared", rs1_busy, 0);
    chk("t6_ready", alu_ready, 1);
    repeat (8) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
